// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with pending scoreboard and runtime clear sequencer
// Optional write-through read bypass is enabled by defining RF_BYPASS_EN.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    output logic [NUM_RD-1:0]        o_rd_pend,
    input  logic                     i_wr0_en,
    input  logic [ADDR_W-1:0]        i_wr0_addr,
    input  logic [DATA_W-1:0]        i_wr0_data,
    input  logic                     i_wr1_en,
    input  logic [ADDR_W-1:0]        i_wr1_addr,
    input  logic [DATA_W-1:0]        i_wr1_data,
    input  logic                     i_pend_set,
    input  logic [ADDR_W-1:0]        i_pend_addr,
    input  logic                     i_clr,
    output logic                     o_busy,
    output logic                     o_clr_done
);
    localparam int DEPTH = 2**ADDR_W;
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              busy_q, done_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic              wr0_ok, wr1_ok, pset_ok;
    assign wr0_ok  = i_wr0_en && !busy_q && !(ZERO_REG == 1 && i_wr0_addr == '0);
    assign wr1_ok  = i_wr1_en && !busy_q && !(ZERO_REG == 1 && i_wr1_addr == '0);
    assign pset_ok = i_pend_set && !busy_q && !(ZERO_REG == 1 && i_pend_addr == '0);
    assign o_busy     = busy_q;
    assign o_clr_done = done_q;
    // next array and scoreboard state: clear slot, else writes (port 1 last) then pend set overriding
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i]  = mem_q[i];
            pend_d[i] = pend_q[i];
            if (busy_q && idx_q == ADDR_W'(i)) begin
                mem_d[i]  = '0;
                pend_d[i] = 1'b0;
            end
            if (wr0_ok && i_wr0_addr == ADDR_W'(i)) begin
                mem_d[i]  = i_wr0_data;
                pend_d[i] = 1'b0;
            end
            if (wr1_ok && i_wr1_addr == ADDR_W'(i)) begin
                mem_d[i]  = i_wr1_data;
                pend_d[i] = 1'b0;
            end
            if (pset_ok && i_pend_addr == ADDR_W'(i)) pend_d[i] = 1'b1;
        end
    end
    // register array and pending bits
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end
    // clear sequencer with registered busy and done outputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (i_clr) begin
                    state_q <= CLEAR;
                    idx_q   <= '0;
                    busy_q  <= 1'b1;
                end
            end else begin
                idx_q <= idx_q + ADDR_W'(1);
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            end
        end
    end
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              z;
        assign a = i_rd_addr[k*ADDR_W +: ADDR_W];
        assign z = ZERO_REG == 1 && a == '0;
`ifdef RF_BYPASS_EN
        logic b0, b1;
        assign b0 = wr0_ok && i_wr0_addr == a;
        assign b1 = wr1_ok && i_wr1_addr == a;
        assign o_rd_data[k*DATA_W +: DATA_W] = z ? '0 : b1 ? i_wr1_data : b0 ? i_wr0_data : mem_q[a];
        assign o_rd_pend[k] = z ? 1'b0 : (b0 || b1) ? (pset_ok && i_pend_addr == a) : pend_q[a];
`else
        assign o_rd_data[k*DATA_W +: DATA_W] = z ? '0 : mem_q[a];
        assign o_rd_pend[k] = !z && pend_q[a];
`endif
    end
endmodule
